s1488_state_reg: RTL

// - State-register stage directly downstream of the s1488 next-state cones (incl. the n60 cone).
// - Registers the 6 next-state bits each clock; feeds them back as state inputs v7..v12.
// - Adds a 6-bit scan chain and an optional self-test run controller with a MISR signature, so

---
 rtl/s1488_state_reg.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/s1488_state_reg.sv
// s1488_state_reg: state-register stage behind the s1488 next-state cones.
// Captures the six next-state bits every clock and returns them as v7..v12.
// Also provides a 6-bit scan chain (scan_in -> q[0] ... q[5] -> scan_out).
// Optional self-test controller (IDLE/RUN/DONE) with a 16-bit MISR over ns,
// present only when the macro S1488_BIST_EN is defined. Without it, bist_start
// is ignored and all self-test outputs are tied to zero.
module s1488_state_reg #(
    parameter int NSTATE     = 6,   // only 6 is supported (fixed v7..v12 mapping)
    parameter int MISR_W     = 16,
    parameter int RUN_CYCLES = 64,  // 1 .. 2**CNT_W-1
    parameter int CNT_W      = 8
) (
    input  logic              CK,
    input  logic              RST,
    input  logic [NSTATE-1:0] ns,
    output logic [NSTATE-1:0] q,
    input  logic              scan_en,
    input  logic              scan_in,
    output logic              scan_out,
    input  logic              bist_start,
    output logic              bist_busy,
    output logic              bist_done,
    output logic [MISR_W-1:0] signature,
    output logic [CNT_W-1:0]  cycle_cnt
);

    logic [NSTATE-1:0] q_reg;
    logic [NSTATE-1:0] q_next;
    logic [NSTATE-1:0] shift_vec;

    // Scan shift vector: scan_in enters bit 0, every other bit takes its lower neighbour.
    genvar gi;
    generate
        for (gi = 0; gi < NSTATE; gi++) begin : g_shift
            if (gi == 0) begin : g_head
                assign shift_vec[gi] = scan_in;
            end else begin : g_body
                assign shift_vec[gi] = q_reg[gi-1];
            end
        end
    endgenerate

`ifdef S1488_BIST_EN
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // x^16+x^12+x^3+x+1, the x^16 term is implied by the shift-out bit.
    localparam logic [MISR_W-1:0] MISR_POLY = MISR_W'(16'h100B);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(RUN_CYCLES - 1);

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic [MISR_W-1:0] sig_reg;
    logic [MISR_W-1:0] sig_next;
    logic [MISR_W-1:0] misr_step;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;

    // One MISR step, folding in the same ns that is being captured into q.
    assign misr_step = {sig_reg[MISR_W-2:0], 1'b0}
                     ^ (sig_reg[MISR_W-1] ? MISR_POLY : '0)
                     ^ {{(MISR_W-NSTATE){1'b0}}, ns};

    // Next-state logic: RUN always captures functionally; IDLE/DONE honour start, then scan.
    always_comb begin
        state_next = state_reg;
        sig_next   = sig_reg;
        cnt_next   = cnt_reg;
        q_next     = ns;
        case (state_reg)
            ST_RUN: begin
                q_next   = ns;
                sig_next = misr_step;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_CNT) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                // IDLE and DONE (and the unused encoding, which behaves as IDLE)
                if (bist_start) begin
                    state_next = ST_RUN;
                    sig_next   = '1;
                    cnt_next   = '0;
                    q_next     = ns;
                end else if (scan_en) begin
                    q_next = shift_vec;
                end else begin
                    q_next = ns;
                end
            end
        endcase
    end

    // State, signature, counter and capture registers with synchronous reset.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_reg <= ST_IDLE;
            sig_reg   <= '0;
            cnt_reg   <= '0;
            q_reg     <= '0;
        end else begin
            state_reg <= state_next;
            sig_reg   <= sig_next;
            cnt_reg   <= cnt_next;
            q_reg     <= q_next;
        end
    end

    assign bist_busy = (state_reg == ST_RUN);
    assign bist_done = (state_reg == ST_DONE);
    assign signature = sig_reg;
    assign cycle_cnt = cnt_reg;
`else
    // Self-test absent: start request has no effect.
    logic unused_bist_start;
    assign unused_bist_start = bist_start;

    // Plain capture or scan shift, exactly as the idle state of the full version.
    always_comb begin
        q_next = ns;
        if (scan_en) begin
            q_next = shift_vec;
        end
    end

    // Capture register with synchronous reset.
    always_ff @(posedge CK) begin
        if (RST) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign bist_busy = 1'b0;
    assign bist_done = 1'b0;
    assign signature = '0;
    assign cycle_cnt = '0;
`endif

    assign q        = q_reg;
    assign scan_out = q_reg[NSTATE-1];

endmodule
